// File: rtl/systolic_array_sequencer_pkg.sv
// systolic_array_sequencer_pkg: shared state encoding and sizing helpers for the sequencer
package systolic_array_sequencer_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;
   // Cycles for the last skewed operand to reach and settle in the corner PE
   function automatic int flush_cycles(input int dim);
      return 2 * dim - 1;
   endfunction
   function automatic int cnt_width(input int dim);
      return $clog2(2 * dim);
   endfunction
endpackage

// File: rtl/systolic_array_sequencer_valid_skew_line.sv
// valid_skew_line: triangular delay line, lane r carries i_valid delayed r cycles
//   clk, rst_n : clock, async active-low reset
//   i_valid    : undelayed valid (lane 0 passes it straight through)
//   o_lane     : per-lane skewed valids
module valid_skew_line
   import systolic_array_sequencer_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic [LANES-1:0] o_lane
);
   // Lanes share one shift chain: tap r-1 is exactly r cycles old
   logic [LANES-2:0] r_tap;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_tap <= '0;
      else r_tap <= (LANES-1)'({r_tap, i_valid});
   assign o_lane = {r_tap, i_valid};
endmodule

// File: rtl/systolic_array_sequencer.sv
// systolic_array_sequencer: command/feed/flush/drain control for an ARRAY_DIM^2 MAC grid
//   clk, rst_n                     : clock, async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_k : matmul command with reduction length
//   i_in_valid/o_in_ready          : one operand step per fire
//   o_act_lane_valid/o_wgt_lane_valid : skewed edge valids
//   o_pe_rst, o_pe_shift           : broadcast clear / accumulator shift
//   i_drain_data -> o_out_data     : result beats, o_out_valid/i_out_ready handshake
//   o_done                         : pulse after last beat
module systolic_array_sequencer
   import systolic_array_sequencer_pkg::*;
#(
   parameter int ARRAY_DIM       = 4,
   parameter int DATA_WIDTH_BITS = 16,
   parameter int K_WIDTH         = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_cmd_valid,
   output logic                                 o_cmd_ready,
   input  logic [K_WIDTH-1:0]                   i_cmd_k,
   input  logic                                 i_in_valid,
   output logic                                 o_in_ready,
   output logic [ARRAY_DIM-1:0]                 o_act_lane_valid,
   output logic [ARRAY_DIM-1:0]                 o_wgt_lane_valid,
   output logic                                 o_pe_rst,
   output logic                                 o_pe_shift,
   input  logic [ARRAY_DIM*DATA_WIDTH_BITS-1:0] i_drain_data,
   output logic                                 o_out_valid,
   input  logic                                 i_out_ready,
   output logic [ARRAY_DIM*DATA_WIDTH_BITS-1:0] o_out_data,
   output logic                                 o_done
);
   localparam int FC = flush_cycles(ARRAY_DIM);
   localparam int CW = cnt_width(ARRAY_DIM);
   state_t             r_state, w_next;
   logic [K_WIDTH-1:0] r_k_rem;
   logic [CW-1:0]      r_cnt;
   logic               r_done, r_live;
   logic               w_fire, w_accept, w_last_beat, w_flush_end, w_cnt_inc;
   assign w_fire      = i_in_valid & o_in_ready;
   assign w_accept    = o_out_valid & i_out_ready;
   assign w_last_beat = r_cnt == CW'(ARRAY_DIM - 1);
   assign w_flush_end = r_cnt == CW'(FC - 1);
   assign w_cnt_inc   = (r_state == FLUSH) | w_accept;
   assign o_out_data  = i_drain_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = (i_cmd_valid & o_cmd_ready) ? CLEAR : IDLE;
         CLEAR:   w_next = (r_k_rem != '0) ? FEED : FLUSH;
         FEED:    w_next = (w_fire && r_k_rem == K_WIDTH'(1)) ? FLUSH : FEED;
         FLUSH:   w_next = w_flush_end ? DRAIN : FLUSH;
         DRAIN:   w_next = (w_accept & w_last_beat) ? IDLE : DRAIN;
         default: w_next = IDLE;
      endcase
   end
   // r_live holds cmd_ready low until the first clock after reset release
   always_comb begin
      o_cmd_ready = r_live & (r_state == IDLE);
      o_in_ready  = r_state == FEED;
      o_pe_rst    = r_state == CLEAR;
      o_out_valid = r_state == DRAIN;
      o_pe_shift  = (r_state == DRAIN) & i_out_ready;
      o_done      = r_done;
   end
   // r_cnt restarts on every state change, so it times FLUSH and counts DRAIN beats
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_live  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_k_rem <= '0;
      end else begin
         r_live  <= 1'b1;
         r_done  <= w_accept & w_last_beat;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(w_cnt_inc);
         if (r_state == IDLE && i_cmd_valid && o_cmd_ready) r_k_rem <= i_cmd_k;
         else if (w_fire) r_k_rem <= r_k_rem - K_WIDTH'(1);
      end
   valid_skew_line #(.LANES(ARRAY_DIM)) u_act_skew (
      .clk(clk), .rst_n(rst_n), .i_valid(w_fire), .o_lane(o_act_lane_valid)
   );
   valid_skew_line #(.LANES(ARRAY_DIM)) u_wgt_skew (
      .clk(clk), .rst_n(rst_n), .i_valid(w_fire), .o_lane(o_wgt_lane_valid)
   );
endmodule
